// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, instruction field positions, status bit
// indices and the default program-counter width.
package sisc_pkg;

  localparam int PC_W_DEF = 16;

  typedef enum logic [3:0] {
    OP_NOOP = 4'h0,
    OP_ALU  = 4'h1,
    OP_LOD  = 4'h2,
    OP_STR  = 4'h3,
    OP_BRA  = 4'h4,
    OP_BRR  = 4'h5,
    OP_BNE  = 4'h6,
    OP_BNR  = 4'h7,
    OP_HLT  = 4'hF
  } opcode_e;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;
  localparam int MM_HI  = 27;
  localparam int MM_LO  = 24;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  // Status register layout {C,V,N,Z}
  localparam int STAT_C = 3;
  localparam int STAT_V = 2;
  localparam int STAT_N = 1;
  localparam int STAT_Z = 0;

endpackage

// File: rtl/br_cond.sv
// Combinational branch resolver: decides whether the branch held in IR is
// taken given the mask field and the latched status flags.
module br_cond
  import sisc_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] mm,
  input  logic [3:0] stat,
  output logic       br_taken
);

  logic mask_hit;

  assign mask_hit = (mm & stat) != 4'b0000;

  always_comb begin
    br_taken = 1'b0;
    case (opcode)
      OP_BRA, OP_BRR: br_taken = (mm == 4'b0000) || mask_hit;
      OP_BNE, OP_BNR: br_taken = !mask_hit;
      default:        br_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// SISC fetch datapath: PC, IR, status register and sticky halt flag.
// Optional branch statistics counters are built when FETCH_BR_STATS_EN is defined.
module fetch_unit
  import sisc_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            pc_rst,
  input  logic            pc_write,
  input  logic            pc_sel,
  input  logic            br_sel,
  input  logic            ir_load,
  input  logic            stat_en,
  input  logic [3:0]      alu_stat,
  input  logic [31:0]     imem_data,
  output logic [PC_W-1:0] pc_out,
  output logic [31:0]     ir,
  output logic [3:0]      opcode,
  output logic [3:0]      mm,
  output logic [15:0]     imm,
  output logic [3:0]      stat,
  output logic            br_taken,
`ifdef FETCH_BR_STATS_EN
  output logic [15:0]     br_total_cnt,
  output logic [15:0]     br_taken_cnt,
`endif
  output logic            halted
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] pc_next;
  logic            pc_upd;

  assign opcode = ir[OPC_HI:OPC_LO];
  assign mm     = ir[MM_HI:MM_LO];
  assign imm    = ir[IMM_HI:IMM_LO];
  assign pc_out = pc;

  br_cond u_br_cond (
    .opcode   (opcode),
    .mm       (mm),
    .stat     (stat),
    .br_taken (br_taken)
  );

  // Relative offsets are signed so a 16-bit imm can step backwards on any PC_W.
  assign pc_inc    = pc + PC_W'(1);
  assign br_target = br_sel ? PC_W'(imm) : pc + PC_W'($signed(imm));

  always_comb begin
    pc_next = pc;
    if (!pc_sel)       pc_next = pc_inc;
    else if (br_taken) pc_next = br_target;
  end

  assign pc_upd = !pc_rst && !halted && pc_write;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc     <= RESET_PC;
      ir     <= '0;
      stat   <= '0;
      halted <= 1'b0;
    end else begin
      if (stat_en) stat <= alu_stat;
      if (!halted && ir_load) ir <= imem_data;
      if (pc_rst) begin
        pc     <= RESET_PC;
        halted <= 1'b0;
      end else if (!halted) begin
        if (pc_write) pc <= pc_next;
        if (ir_load && imem_data[OPC_HI:OPC_LO] == OP_HLT) halted <= 1'b1;
      end
    end
  end

`ifdef FETCH_BR_STATS_EN
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      br_total_cnt <= '0;
      br_taken_cnt <= '0;
    end else if (pc_upd && pc_sel) begin
      if (br_total_cnt != 16'hFFFF) br_total_cnt <= br_total_cnt + 16'd1;
      if (br_taken && br_taken_cnt != 16'hFFFF) br_taken_cnt <= br_taken_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential fetch, branches, wrap,
// status race, halt and asynchronous reset mid-instruction.
module tb_fetch_unit;
  import sisc_pkg::*;

  logic        clk;
  logic        rst_f;
  logic        pc_rst;
  logic        pc_write;
  logic        pc_sel;
  logic        br_sel;
  logic        ir_load;
  logic        stat_en;
  logic [3:0]  alu_stat;
  logic [31:0] imem_data;
  logic [15:0] pc_out;
  logic [31:0] ir;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] imm;
  logic [3:0]  stat;
  logic        br_taken;
  logic        halted;
`ifdef FETCH_BR_STATS_EN
  logic [15:0] br_total_cnt;
  logic [15:0] br_taken_cnt;
`endif

  logic        use_mem;
  logic [31:0] imem_drv;
  logic [31:0] exp_q[$];
  int          tests_run;
  int          tests_failed;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'hA5C3, a};
  endfunction

  assign imem_data = use_mem ? mem_word(pc_out) : imem_drv;

  fetch_unit dut (
    .clk          (clk),
    .rst_f        (rst_f),
    .pc_rst       (pc_rst),
    .pc_write     (pc_write),
    .pc_sel       (pc_sel),
    .br_sel       (br_sel),
    .ir_load      (ir_load),
    .stat_en      (stat_en),
    .alu_stat     (alu_stat),
    .imem_data    (imem_data),
    .pc_out       (pc_out),
    .ir           (ir),
    .opcode       (opcode),
    .mm           (mm),
    .imm          (imm),
    .stat         (stat),
    .br_taken     (br_taken),
`ifdef FETCH_BR_STATS_EN
    .br_total_cnt (br_total_cnt),
    .br_taken_cnt (br_taken_cnt),
`endif
    .halted       (halted)
  );

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_rst = 0; pc_write = 0; pc_sel = 0; br_sel = 0;
    ir_load = 0; stat_en = 0; alu_stat = 0; use_mem = 0; imem_drv = 0;
  endtask

  task automatic load_ir(input logic [31:0] w);
    use_mem = 0; imem_drv = w; ir_load = 1;
    step();
    ir_load = 0;
  endtask

  task automatic set_stat(input logic [3:0] s);
    stat_en = 1; alu_stat = s;
    step();
    stat_en = 0;
  endtask

  task automatic set_pc(input logic [15:0] v);
    load_ir({OP_BRA, 4'b0000, 8'h00, v});
    pc_write = 1; pc_sel = 1; br_sel = 1;
    step();
    pc_write = 0; pc_sel = 0; br_sel = 0;
  endtask

  task automatic branch(input logic abs_sel);
    pc_write = 1; pc_sel = 1; br_sel = abs_sel;
    step();
    pc_write = 0; pc_sel = 0; br_sel = 0;
  endtask

  // scenarios
  task automatic test_reset();
    idle_inputs();
    rst_f = 0;
    #3;
    tests_run++; if (pc_out !== 16'h0000) begin tests_failed++; $display("FAIL reset_pc got %h exp 0000", pc_out); end
    tests_run++; if (ir !== 32'h0) begin tests_failed++; $display("FAIL reset_ir got %h exp 0", ir); end
    tests_run++; if (stat !== 4'h0) begin tests_failed++; $display("FAIL reset_stat got %h exp 0", stat); end
    tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("FAIL reset_halted got %b exp 0", halted); end
    tests_run++; if ({opcode, mm, imm, br_taken} !== 25'h0) begin tests_failed++; $display("FAIL reset_fields got %h/%h/%h/%b exp 0", opcode, mm, imm, br_taken); end
`ifdef FETCH_BR_STATS_EN
    tests_run++; if ({br_total_cnt, br_taken_cnt} !== 32'h0) begin tests_failed++; $display("FAIL reset_cnt got %h/%h exp 0", br_total_cnt, br_taken_cnt); end
`endif
    @(negedge clk);
    rst_f = 1;
    step();
  endtask

  task automatic test_seq_fetch();
    for (int i = 0; i < 3; i++) exp_q.push_back(mem_word(16'(i)));
    use_mem = 1; ir_load = 1; pc_write = 1; pc_sel = 0;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] e;
      step();
      e = exp_q.pop_front();
      tests_run++; if (pc_out !== 16'(i + 1)) begin tests_failed++; $display("FAIL seq_pc[%0d] got %h exp %h", i, pc_out, 16'(i + 1)); end
      tests_run++; if (ir !== e) begin tests_failed++; $display("FAIL seq_ir[%0d] got %h exp %h", i, ir, e); end
    end
    idle_inputs();
  endtask

  task automatic test_cond_branch();
    set_stat(4'b0001);
    set_pc(16'h0010);
    load_ir({OP_BRR, 4'b0001, 8'h00, 16'hFFFE});
    tests_run++; if (br_taken !== 1'b1) begin tests_failed++; $display("FAIL brr_z_taken got %b exp 1", br_taken); end
    branch(0);
    tests_run++; if (pc_out !== 16'h000E) begin tests_failed++; $display("FAIL brr_z_pc got %h exp 000E", pc_out); end
    set_stat(4'b0000);
    set_pc(16'h0010);
    load_ir({OP_BRR, 4'b0001, 8'h00, 16'hFFFE});
    tests_run++; if (br_taken !== 1'b0) begin tests_failed++; $display("FAIL brr_nz_taken got %b exp 0", br_taken); end
    branch(0);
    tests_run++; if (pc_out !== 16'h0010) begin tests_failed++; $display("FAIL brr_nz_pc got %h exp 0010", pc_out); end
    // non-branch opcode with pc_sel=1 leaves PC alone
    load_ir({OP_ALU, 4'b0000, 8'h00, 16'h0040});
    branch(1);
    tests_run++; if (pc_out !== 16'h0010) begin tests_failed++; $display("FAIL alu_pcsel_pc got %h exp 0010", pc_out); end
  endtask

  task automatic test_abs_bne();
    set_stat(4'b0100);
    load_ir({OP_BNE, 4'b0100, 8'h00, 16'h1234});
    tests_run++; if (br_taken !== 1'b0) begin tests_failed++; $display("FAIL bne_hit_taken got %b exp 0", br_taken); end
    branch(1);
    tests_run++; if (pc_out !== 16'h0010) begin tests_failed++; $display("FAIL bne_hit_pc got %h exp 0010", pc_out); end
    set_stat(4'b0000);
    tests_run++; if (br_taken !== 1'b1) begin tests_failed++; $display("FAIL bne_miss_taken got %b exp 1", br_taken); end
    branch(1);
    tests_run++; if (pc_out !== 16'h1234) begin tests_failed++; $display("FAIL bne_miss_pc got %h exp 1234", pc_out); end
    // BNR with a mask bit clear in stat is taken, relative
    set_stat(4'b1000);
    load_ir({OP_BNR, 4'b0010, 8'h00, 16'h0003});
    branch(0);
    tests_run++; if (pc_out !== 16'h1237) begin tests_failed++; $display("FAIL bnr_pc got %h exp 1237", pc_out); end
  endtask

  task automatic test_wrap_race();
    set_pc(16'hFFFF);
    pc_write = 1; pc_sel = 0;
    step();
    pc_write = 0;
    tests_run++; if (pc_out !== 16'h0000) begin tests_failed++; $display("FAIL inc_wrap got %h exp 0000", pc_out); end
    set_pc(16'hFFF0);
    load_ir({OP_BRA, 4'b0000, 8'h00, 16'h0020});
    branch(0);
    tests_run++; if (pc_out !== 16'h0010) begin tests_failed++; $display("FAIL rel_wrap got %h exp 0010", pc_out); end
    // new status in the branch cycle must not affect that branch
    set_stat(4'b0001);
    set_pc(16'h0100);
    load_ir({OP_BRR, 4'b0001, 8'h00, 16'h0005});
    stat_en = 1; alu_stat = 4'b0000;
    branch(0);
    stat_en = 0;
    tests_run++; if (pc_out !== 16'h0105) begin tests_failed++; $display("FAIL race_old_taken_pc got %h exp 0105", pc_out); end
    tests_run++; if (stat !== 4'b0000 || br_taken !== 1'b0) begin tests_failed++; $display("FAIL race_new_stat got %h/%b exp 0/0", stat, br_taken); end
    stat_en = 1; alu_stat = 4'b0001;
    branch(0);
    stat_en = 0;
    tests_run++; if (pc_out !== 16'h0105) begin tests_failed++; $display("FAIL race_old_nt_pc got %h exp 0105", pc_out); end
  endtask

  task automatic test_halt();
    set_pc(16'h0200);
    use_mem = 0; imem_drv = {OP_HLT, 28'h0}; ir_load = 1; pc_write = 1; pc_sel = 0;
    step();
    tests_run++; if (halted !== 1'b1 || opcode !== 4'hF) begin tests_failed++; $display("FAIL halt_set got %b/%h exp 1/f", halted, opcode); end
    tests_run++; if (pc_out !== 16'h0201) begin tests_failed++; $display("FAIL halt_load_pc got %h exp 0201", pc_out); end
    imem_drv = {OP_BRA, 28'h0000055};
    step();
    step();
    tests_run++; if (pc_out !== 16'h0201 || ir !== {OP_HLT, 28'h0}) begin tests_failed++; $display("FAIL halt_gate got %h/%h exp 0201/f0000000", pc_out, ir); end
    ir_load = 0; pc_write = 0; pc_rst = 1;
    step();
    pc_rst = 0;
    tests_run++; if (pc_out !== 16'h0000 || halted !== 1'b0) begin tests_failed++; $display("FAIL pc_rst got %h/%b exp 0000/0", pc_out, halted); end
    tests_run++; if (ir !== {OP_HLT, 28'h0}) begin tests_failed++; $display("FAIL pc_rst_ir got %h exp f0000000", ir); end
    pc_write = 1; pc_sel = 0;
    step();
    pc_write = 0;
    tests_run++; if (pc_out !== 16'h0001) begin tests_failed++; $display("FAIL post_halt_pc got %h exp 0001", pc_out); end
  endtask

  task automatic test_back_to_back();
    set_stat(4'b0110);
    set_pc(16'h0333);
    @(posedge clk);
    #3;
    rst_f = 0;
    #1;
    tests_run++; if (pc_out !== 16'h0000 || ir !== 32'h0 || stat !== 4'h0) begin tests_failed++; $display("FAIL midreset got %h/%h/%h exp 0/0/0", pc_out, ir, stat); end
    @(negedge clk);
    rst_f = 1;
    use_mem = 1; ir_load = 1; pc_write = 1; pc_sel = 0;
    step();
    idle_inputs();
    tests_run++; if (ir !== mem_word(16'h0000) || pc_out !== 16'h0001) begin tests_failed++; $display("FAIL first_fetch got %h/%h exp %h/0001", ir, pc_out, mem_word(16'h0000)); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_seq_fetch();
    test_cond_branch();
    test_abs_bne();
    test_wrap_race();
    test_halt();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
